// File: rtl/fwd_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// fwd_hazard_unit_if : ID-stage request / EX-stage forwarding response bundle
// Rev 1.0
// ============================================================================
interface fwd_hazard_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int REG_W   = 5,
  parameter int LAT_W   = 2,
  parameter int SEL_W   = $clog2(DEPTH + 1)
);
  logic                     id_valid;
  logic [NUM_SRC*REG_W-1:0] id_rs;
  logic [NUM_SRC-1:0]       id_rs_used;
  logic [REG_W-1:0]         id_rd;
  logic                     id_reg_write;
  logic [LAT_W-1:0]         id_lat;
  logic                     flush;
  logic                     stall;
  logic                     ex_valid;
  logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel;
  logic [31:0]              stall_count;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_lat, flush,
    input  stall, ex_valid, ex_fwd_sel, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_lat, flush,
    output stall, ex_valid, ex_fwd_sel, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// fwd_hazard_unit : forwarding select and load-use / multi-cycle stall control
// at the ID/EX boundary.  Rev 1.0
// ============================================================================
module fwd_hazard_unit #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int REG_W   = 5,
  parameter int LAT_W   = 2,
  parameter int SEL_W   = $clog2(DEPTH + 1)
) (
  input  wire logic        clk,
  input  wire logic        rst,
  fwd_hazard_unit_if.slave bus
);
  localparam int C_MAX_LAT = DEPTH - 1;

  logic [DEPTH-1:0]         valid_q;
  logic [DEPTH-1:0]         wen_q;
  logic [REG_W-1:0]         rd_q  [DEPTH];
  logic [LAT_W-1:0]         lat_q [DEPTH];
  logic                     ex_valid_q;
  logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel_q;
  logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel_d;
  logic [31:0]              stall_cnt_q;

  int                       w_eff_lat [DEPTH];
  logic [NUM_SRC-1:0]       w_found;
  logic [NUM_SRC-1:0]       w_not_ready;
  logic                     w_stall;
  logic                     w_accept;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_eff_lat[k] = (int'(lat_q[k]) > C_MAX_LAT) ? C_MAX_LAT : int'(lat_q[k]);
    end
  end

  // Scan entries youngest-first; only the first match per source counts.
  always_comb begin
    w_found      = '0;
    w_not_ready  = '0;
    ex_fwd_sel_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!w_found[i] && valid_q[k] && wen_q[k] && bus.id_rs_used[i] &&
            (rd_q[k] == bus.id_rs[i*REG_W +: REG_W]) && (rd_q[k] != '0)) begin
          w_found[i] = 1'b1;
          if (k < w_eff_lat[k]) begin
            w_not_ready[i] = 1'b1;
          end else begin
            ex_fwd_sel_d[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          end
        end
      end
    end
  end

  assign w_stall  = bus.id_valid & ~bus.flush & (|w_not_ready);
  assign w_accept = bus.id_valid & ~w_stall & ~bus.flush;

  // Metadata shifts unconditionally; only the valid bits need reset/flush.
  always_ff @(posedge clk) begin
    for (int k = DEPTH - 1; k > 0; k--) begin
      rd_q[k]  <= rd_q[k-1];
      wen_q[k] <= wen_q[k-1];
      lat_q[k] <= lat_q[k-1];
    end
    rd_q[0]  <= bus.id_rd;
    wen_q[0] <= bus.id_reg_write;
    lat_q[0] <= bus.id_lat;

    if (rst) begin
      valid_q      <= '0;
      ex_valid_q   <= 1'b0;
      ex_fwd_sel_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (bus.flush) begin
        valid_q <= '0;
      end else begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          valid_q[k] <= valid_q[k-1];
        end
        valid_q[0] <= w_accept;
      end
      ex_valid_q   <= w_accept;
      ex_fwd_sel_q <= w_accept ? ex_fwd_sel_d : '0;
      if (w_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign bus.stall       = w_stall;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_fwd_sel  = ex_fwd_sel_q;
  assign bus.stall_count = stall_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// tb_fwd_hazard_unit : directed vectors for fwd_hazard_unit
// Rev 1.0
// ============================================================================
module tb_fwd_hazard_unit;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 3;
  localparam int REG_W   = 5;
  localparam int LAT_W   = 2;
  localparam int SEL_W   = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fwd_hazard_unit_if #(
    .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .REG_W(REG_W), .LAT_W(LAT_W), .SEL_W(SEL_W)
  ) bus ();

  fwd_hazard_unit #(
    .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .REG_W(REG_W), .LAT_W(LAT_W), .SEL_W(SEL_W)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] used,
                       input logic [4:0] rd, input logic wen, input logic [1:0] lat);
    bus.id_valid     = 1'b1;
    bus.id_rs        = {rs2, rs1};
    bus.id_rs_used   = used;
    bus.id_rd        = rd;
    bus.id_reg_write = wen;
    bus.id_lat       = lat;
    #1;
  endtask

  task automatic idle();
    bus.id_valid     = 1'b0;
    bus.id_rs        = '0;
    bus.id_rs_used   = '0;
    bus.id_rd        = '0;
    bus.id_reg_write = 1'b0;
    bus.id_lat       = '0;
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (DEPTH) step();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.flush = 1'b0;
    idle();
    repeat (2) step();
    rst = 1'b0;
    #1;

    check_eq("rst_stall", {31'd0, bus.stall}, 32'd0);
    check_eq("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_eq("rst_sel", {28'd0, bus.ex_fwd_sel}, 32'd0);
    check_eq("rst_count", bus.stall_count, 32'd0);

    // ALU dependency
    issue(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2'd0);
    step();
    issue(5'd5, 5'd0, 2'b01, 5'd10, 1'b0, 2'd0);
    check_eq("alu_stall", {31'd0, bus.stall}, 32'd0);
    step();
    check_eq("alu_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    check_eq("alu_sel", {28'd0, bus.ex_fwd_sel}, 32'h1);
    drain();

    // Load-use: one stall cycle then MEM/WB forward on source 1
    issue(5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 2'd1);
    step();
    issue(5'd0, 5'd6, 2'b10, 5'd11, 1'b0, 2'd0);
    check_eq("lu_stall1", {31'd0, bus.stall}, 32'd1);
    step();
    check_eq("lu_bubble", {31'd0, bus.ex_valid}, 32'd0);
    check_eq("lu_stall2", {31'd0, bus.stall}, 32'd0);
    check_eq("lu_count", bus.stall_count, 32'd1);
    step();
    check_eq("lu_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    check_eq("lu_sel", {28'd0, bus.ex_fwd_sel}, 32'h8);
    drain();

    // Youngest producer wins for both sources
    issue(5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd0);
    step();
    issue(5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd0);
    step();
    issue(5'd7, 5'd7, 2'b11, 5'd0, 1'b0, 2'd0);
    step();
    check_eq("prio_sel", {28'd0, bus.ex_fwd_sel}, 32'h5);
    drain();

    // Producer two ahead
    issue(5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 2'd0);
    step();
    issue(5'd0, 5'd0, 2'b00, 5'd13, 1'b1, 2'd0);
    step();
    issue(5'd12, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0);
    step();
    check_eq("dist2_sel", {28'd0, bus.ex_fwd_sel}, 32'h2);
    drain();

    // Producer three ahead
    issue(5'd0, 5'd0, 2'b00, 5'd14, 1'b1, 2'd0);
    step();
    idle();
    step();
    step();
    issue(5'd14, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0);
    step();
    check_eq("dist3_sel", {28'd0, bus.ex_fwd_sel}, 32'h3);
    drain();

    // Retired producer reads the register file
    issue(5'd0, 5'd0, 2'b00, 5'd15, 1'b1, 2'd0);
    step();
    idle();
    repeat (3) step();
    issue(5'd15, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0);
    step();
    check_eq("retired_sel", {28'd0, bus.ex_fwd_sel}, 32'h0);
    drain();

    // x0 never forwards
    issue(5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 2'd0);
    step();
    issue(5'd0, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0);
    step();
    check_eq("x0_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    check_eq("x0_sel", {28'd0, bus.ex_fwd_sel}, 32'h0);
    drain();

    // Unused source matching a load
    issue(5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 2'd1);
    step();
    issue(5'd3, 5'd9, 2'b01, 5'd0, 1'b0, 2'd0);
    check_eq("unused_stall", {31'd0, bus.stall}, 32'd0);
    step();
    check_eq("unused_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    check_eq("unused_sel", {28'd0, bus.ex_fwd_sel}, 32'h0);
    drain();

    // Flush during stall
    issue(5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 2'd1);
    step();
    issue(5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0);
    check_eq("fl_stall_pre", {31'd0, bus.stall}, 32'd1);
    bus.flush = 1'b1;
    #1;
    check_eq("fl_stall_cut", {31'd0, bus.stall}, 32'd0);
    step();
    bus.flush = 1'b0;
    #1;
    check_eq("fl_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_eq("fl_sel", {28'd0, bus.ex_fwd_sel}, 32'h0);
    check_eq("fl_reissue_stall", {31'd0, bus.stall}, 32'd0);
    step();
    check_eq("fl_reissue_sel", {28'd0, bus.ex_fwd_sel}, 32'h0);
    check_eq("fl_count", bus.stall_count, 32'd1);
    drain();

    // Latency 3 clamps to 2: two stall cycles, then code 3
    issue(5'd0, 5'd0, 2'b00, 5'd20, 1'b1, 2'd3);
    step();
    issue(5'd20, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0);
    check_eq("mc_stall1", {31'd0, bus.stall}, 32'd1);
    step();
    check_eq("mc_stall2", {31'd0, bus.stall}, 32'd1);
    step();
    check_eq("mc_stall3", {31'd0, bus.stall}, 32'd0);
    check_eq("mc_count", bus.stall_count, 32'd3);
    step();
    check_eq("mc_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
    check_eq("mc_sel", {28'd0, bus.ex_fwd_sel}, 32'h3);
    drain();

    // Reset mid-stall
    issue(5'd0, 5'd0, 2'b00, 5'd21, 1'b1, 2'd1);
    step();
    issue(5'd21, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0);
    check_eq("rs_stall_pre", {31'd0, bus.stall}, 32'd1);
    rst = 1'b1;
    step();
    check_eq("rs_stall", {31'd0, bus.stall}, 32'd0);
    check_eq("rs_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_eq("rs_sel", {28'd0, bus.ex_fwd_sel}, 32'h0);
    check_eq("rs_count", bus.stall_count, 32'd0);
    rst = 1'b0;
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
